fetch_unit: RTL and testbench

Instruction fetch stage feeding the instruction queue ahead of decode. Holds the PC and a 64-bit commit-order counter, fetches 256-bit lines from the instruction cache's upstream port, and keeps the last line in a one-entry line buffer. From that buffer it enqueues one `{order, pc, inst}` packet per cycle into the instruction queue, and accepts PC redirects.

---
 rtl/rv32i_types.sv | 30 +++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_line_buffer.sv | 54 +++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: fetch FSM states, the instruction-queue packet layout
// and line geometry used by the fetch stage.
package rv32i_types;

  localparam int FETCH_LINE_WORDS = 8;
  localparam int FETCH_TAG_BITS   = 27;

  typedef enum logic [0:0] {
    S_LOOKUP = 1'b0,
    S_REQ    = 1'b1
  } fetch_state_t;

  // Field order matches iq_data bit order, MSB first.
  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  function automatic fetch_pkt_t make_fetch_pkt(input logic [63:0] order,
                                                input logic [31:0] pc,
                                                input logic [31:0] inst);
    fetch_pkt_t pkt;
    pkt.order = order;
    pkt.pc    = pc;
    pkt.inst  = inst;
    return pkt;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: cache upstream port, instruction-queue port and
// back-end control. master = fetch unit, slave = its environment.
interface fetch_unit_if #(
  parameter int LINE_BITS = 256
);
  logic [31:0]          ufp_addr;
  logic [3:0]           ufp_rmask;
  logic [LINE_BITS-1:0] ufp_rline;
  logic                 ufp_resp;
  logic [127:0]         iq_data;
  logic                 iq_enqueue;
  logic                 iq_full;
  logic                 stall;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;

  modport master (
    output ufp_addr, ufp_rmask, iq_data, iq_enqueue,
    input  ufp_rline, ufp_resp, iq_full, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  ufp_addr, ufp_rmask, iq_data, iq_enqueue,
    output ufp_rline, ufp_resp, iq_full, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// One-entry line buffer for the fetch stage: valid/tag/line storage with
// install, invalidate and a combinational hit + word-select lookup.
module fetch_line_buffer
  import rv32i_types::*;
#(
  parameter int LINE_BITS = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_install,
  input  logic [FETCH_TAG_BITS-1:0] i_install_tag,
  input  logic [LINE_BITS-1:0]      i_install_line,
  input  logic                      i_invalidate,
  input  logic                      i_lookup_en,
  input  logic [FETCH_TAG_BITS-1:0] i_lookup_tag,
  input  logic [2:0]                i_word_sel,
  output logic                      o_hit,
  output logic [31:0]               o_word
);

  logic                      r_valid;
  logic [FETCH_TAG_BITS-1:0] r_tag;
  logic [LINE_BITS-1:0]      r_line;
  logic [31:0]               w_words [FETCH_LINE_WORDS];

  // A fresh install wins over a same-cycle invalidate: the returned data is
  // valid for its tag regardless of where the PC has been redirected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
    end else if (i_install) begin
      r_valid <= 1'b1;
    end else if (i_invalidate) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_install) begin
      r_tag  <= i_install_tag;
      r_line <= i_install_line;
    end
  end

  generate
    for (genvar gi = 0; gi < FETCH_LINE_WORDS; gi++) begin : g_word
      assign w_words[gi] = r_line[32*gi +: 32];
    end
  endgenerate

  assign o_hit  = i_lookup_en && r_valid && (r_tag == i_lookup_tag);
  assign o_word = w_words[i_word_sel];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, commit-order counter, line fetch FSM and
// enqueue into the instruction queue. Macro FETCH_LINE_BUFFER_EN enables line reuse.
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC  = 32'haaaaa000,
  parameter int          LINE_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_t              r_state;
  fetch_state_t              w_state_next;
  logic [31:0]               r_pc;
  logic [63:0]               r_order;
  logic [FETCH_TAG_BITS-1:0] r_req_tag;
  logic [31:0]               r_ufp_addr;
  logic [3:0]                r_ufp_rmask;

  logic                      w_hit;
  logic [31:0]               w_word;
  logic                      w_enq;
  logic                      w_miss;
  logic                      w_install;
  logic                      w_invalidate;

  // Without line reuse every enqueue and redirect drops the buffered line,
  // so each instruction pays its own cache round trip.
`ifdef FETCH_LINE_BUFFER_EN
  assign w_invalidate = 1'b0;
`else
  assign w_invalidate = w_enq || bus.redirect_valid;
`endif

  fetch_line_buffer #(
    .LINE_BITS (LINE_BITS)
  ) u_line_buffer (
    .clk            (clk),
    .rst            (rst),
    .i_install      (w_install),
    .i_install_tag  (r_req_tag),
    .i_install_line (bus.ufp_rline),
    .i_invalidate   (w_invalidate),
    .i_lookup_en    (r_state == S_LOOKUP),
    .i_lookup_tag   (r_pc[31:5]),
    .i_word_sel     (r_pc[4:2]),
    .o_hit          (w_hit),
    .o_word         (w_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_LOOKUP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_LOOKUP: if (!bus.redirect_valid && !w_hit) w_state_next = S_REQ;
      S_REQ:    if (bus.ufp_resp) w_state_next = S_LOOKUP;
      default:  w_state_next = S_LOOKUP;
    endcase
  end

  // Redirect takes priority over both enqueue and miss handling in lookup.
  always_comb begin
    w_enq     = 1'b0;
    w_miss    = 1'b0;
    w_install = 1'b0;
    unique case (r_state)
      S_LOOKUP: begin
        if (!bus.redirect_valid) begin
          if (w_hit) begin
            w_enq = !bus.iq_full && !bus.stall;
          end else begin
            w_miss = 1'b1;
          end
        end
      end
      S_REQ:   w_install = bus.ufp_resp;
      default: ;
    endcase
  end

  // A redirect in S_REQ only retargets the PC; the outstanding line still
  // installs under r_req_tag when it returns.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_order     <= 64'd0;
      r_req_tag   <= '0;
      r_ufp_addr  <= 32'd0;
      r_ufp_rmask <= 4'h0;
    end else begin
      if (bus.redirect_valid) begin
        r_pc <= bus.redirect_pc;
      end else if (w_enq) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_enq) begin
        r_order <= r_order + 64'd1;
      end
      if (w_miss) begin
        r_req_tag   <= r_pc[31:5];
        r_ufp_addr  <= {r_pc[31:5], 5'b0};
        r_ufp_rmask <= 4'hf;
      end else if (w_install) begin
        r_ufp_rmask <= 4'h0;
      end
    end
  end

  assign bus.ufp_addr   = r_ufp_addr;
  assign bus.ufp_rmask  = r_ufp_rmask;
  assign bus.iq_enqueue = w_enq;
  assign bus.iq_data    = make_fetch_pkt(r_order, r_pc, w_word);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; the cache model returns
// inst = ~pc for every word, so expected packets follow from the pc alone.
module tb_fetch_unit;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt = 0;
  bit   cache_en = 1'b1;

  always #5 clk = ~clk;

  fetch_unit_if #(.LINE_BITS(256)) bus ();

  fetch_unit #(
    .RESET_PC  (32'haaaaa000),
    .LINE_BITS (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [255:0] make_line(input logic [31:0] addr);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = ~(addr + 32'(4 * i));
    return l;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the cache answers LAT cycles after the request appears.
  task automatic step();
    @(posedge clk);
    #1;
    if (cache_en) begin
      if (bus.ufp_rmask == 4'hf) begin
        cnt++;
        if (cnt == LAT) begin
          bus.ufp_resp  = 1'b1;
          bus.ufp_rline = make_line(bus.ufp_addr);
          cnt = 0;
        end else begin
          bus.ufp_resp = 1'b0;
        end
      end else begin
        bus.ufp_resp = 1'b0;
        cnt = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input bit full, input bit st, input bit rv, input logic [31:0] rpc);
    bus.iq_full        = full;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  task automatic expect_pkt(input logic [31:0] pc, input logic [63:0] order);
    check_val($sformatf("enq_%h", pc), {127'd0, bus.iq_enqueue}, 128'd1);
    check_val($sformatf("pkt_%h", pc), bus.iq_data, {order, pc, ~pc});
    $display("pkt pc=%h order=%0d inst=%h", bus.iq_data[63:32], bus.iq_data[127:64], bus.iq_data[31:0]);
  endtask

  // Starts in the miss cycle, ends in the cycle after the response.
  task automatic miss_fill(input logic [31:0] addr);
    check_val($sformatf("miss_enq_%h", addr), {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    check_val($sformatf("req_rmask_%h", addr), {124'd0, bus.ufp_rmask}, 128'hf);
    check_val("req_addr", {96'd0, bus.ufp_addr}, {96'd0, addr});
    step();
    step();
    check_val($sformatf("resp_enq_%h", addr), {127'd0, bus.iq_enqueue}, 128'd0);
    step();
  endtask

  task automatic ready(input logic [31:0] addr);
`ifdef FETCH_LINE_BUFFER_EN
    check_val($sformatf("hit_%h", addr), {100'd0, bus.iq_enqueue, bus.iq_data[63:37]},
              {100'd0, 1'b1, addr[31:5]});
`else
    miss_fill(addr);
`endif
  endtask

  task automatic pkt_hit(input logic [31:0] pc, input logic [63:0] order);
    ready({pc[31:5], 5'b0});
    expect_pkt(pc, order);
  endtask

  task automatic pkt_miss(input logic [31:0] pc, input logic [63:0] order);
    miss_fill({pc[31:5], 5'b0});
    expect_pkt(pc, order);
  endtask

  initial begin
    bus.ufp_rline = '0;
    bus.ufp_resp  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    step();
    check_val("rst_rmask", {124'd0, bus.ufp_rmask}, 128'd0);
    check_val("rst_addr", {96'd0, bus.ufp_addr}, 128'd0);
    check_val("rst_enq", {127'd0, bus.iq_enqueue}, 128'd0);

    // First line: 8 back-to-back packets, then the next line request.
    rst = 1'b1;
    #1;
    pkt_miss(32'haaaaa000, 64'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      pkt_hit(32'haaaaa000 + 32'(4 * i), 64'(i));
    end
    step();
    pkt_miss(32'haaaaa020, 64'd8);
    step();
    pkt_hit(32'haaaaa024, 64'd9);

    // Queue full for 5 cycles: nothing enqueued, nothing requested.
    step();
    ready(32'haaaaa020);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("full_enq_%0d", i), {127'd0, bus.iq_enqueue}, 128'd0);
      check_val($sformatf("full_rmask_%0d", i), {124'd0, bus.ufp_rmask}, 128'd0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    expect_pkt(32'haaaaa028, 64'd10);
    step();
    pkt_hit(32'haaaaa02c, 64'd11);

    // Redirect during a hit to another line, then within the buffered line.
    step();
    ready(32'haaaaa020);
    drive(1'b0, 1'b0, 1'b1, 32'haaaaa014);
    check_val("redir1_enq", {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    pkt_miss(32'haaaaa014, 64'd12);
    step();
    ready(32'haaaaa000);
    drive(1'b0, 1'b0, 1'b1, 32'haaaaa014);
    check_val("redir2_enq", {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    pkt_hit(32'haaaaa014, 64'd13);

    // Redirect while a request for 0xaaaaa040 is outstanding.
    step();
    ready(32'haaaaa000);
    drive(1'b0, 1'b0, 1'b1, 32'haaaaa040);
    check_val("redir3_enq", {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    check_val("m040_enq", {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    check_val("req040_rmask", {124'd0, bus.ufp_rmask}, 128'hf);
    check_val("req040_addr", {96'd0, bus.ufp_addr}, 128'haaaaa040);
    drive(1'b0, 1'b0, 1'b1, 32'haaaab000);
    check_val("redir_req_enq", {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    check_val("hold_addr", {96'd0, bus.ufp_addr}, 128'haaaaa040);
    step();
    check_val("hold_rmask", {124'd0, bus.ufp_rmask}, 128'hf);
    check_val("hold_addr2", {96'd0, bus.ufp_addr}, 128'haaaaa040);
    step();
    check_val("inst040_rmask", {124'd0, bus.ufp_rmask}, 128'd0);
    pkt_miss(32'haaaab000, 64'd14);

    // Back-end stall for 2 cycles.
    step();
    ready(32'haaaab000);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    check_val("stall_enq0", {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    check_val("stall_enq1", {127'd0, bus.iq_enqueue}, 128'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    expect_pkt(32'haaaab004, 64'd15);

    // Reset while a request is outstanding, with a late response after it.
    step();
    cache_en = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'haaaac000);
    check_val("redir4_enq", {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check_val("reqc000_addr", {96'd0, bus.ufp_addr}, 128'haaaac000);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.ufp_resp  = 1'b1;
    bus.ufp_rline = make_line(32'haaaac000);
    #1;
    check_val("mid_rst_rmask", {124'd0, bus.ufp_rmask}, 128'd0);
    check_val("mid_rst_addr", {96'd0, bus.ufp_addr}, 128'd0);
    check_val("mid_rst_enq", {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    bus.ufp_resp = 1'b0;
    #1;
    check_val("late_resp_rmask", {124'd0, bus.ufp_rmask}, 128'hf);
    check_val("late_resp_addr", {96'd0, bus.ufp_addr}, 128'haaaaa000);
    check_val("late_resp_enq", {127'd0, bus.iq_enqueue}, 128'd0);
    cache_en = 1'b1;
    cnt = 1;
    step();
    step();
    step();
    expect_pkt(32'haaaaa000, 64'd0);

    // PC wrap from 0xfffffffc to 0.
    step();
    drive(1'b0, 1'b0, 1'b1, 32'hfffffff8);
    check_val("redir5_enq", {127'd0, bus.iq_enqueue}, 128'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    pkt_miss(32'hfffffff8, 64'd1);
    step();
    pkt_hit(32'hfffffffc, 64'd2);
    step();
    pkt_miss(32'h00000000, 64'd3);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
